// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and the load/store stage.
// Round-robin on contention, registered memory port, one-cycle acks, sticky timeout.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;  // 1 = data stage won the previous grant
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          timeout_err_q, timeout_err_d;
  logic          timed_out;

  assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!if_req || !last_d_q)) begin
          state_d     = GNT_D;
          last_d_d    = 1'b1;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_req) begin
          state_d     = GNT_IF;
          last_d_d    = 1'b0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ack || timed_out) begin
          // A timeout completes the transaction anyway so the requester never hangs.
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
          if (!mem_ack) timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = timeout_err_q;
  assign stall_if    = if_req & ~if_ack_q;
  assign stall_mem   = d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          stall_if, stall_mem, timeout_err;

  int checks = 0;
  int errors = 0;
  bit grants[$];  // 1 = data stage, 0 = fetch

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Transaction-level model: grant rule from the pending requests, memory with random latency.
  task automatic run_engine(input int ncyc, input bit contend);
    int ph = 0;  // 0 free, 1 granted, 2 ack cycle
    int lat = 0;
    bit win_d = 1'b0, last_d = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic e_we = 1'b0;
    logic [DW-1:0] e_wdata = '0, e_if_rd = '0, e_d_rd = '0;
    logic p_ifr, p_dr, p_dwe, p_ack;
    logic [AW-1:0] p_ifa, p_da;
    logic [DW-1:0] p_dwd, p_rd;
    grants.delete();
    p_ifr = if_req; p_dr = d_req; p_dwe = d_we; p_ack = mem_ack;
    p_ifa = if_addr; p_da = d_addr; p_dwd = d_wdata; p_rd = mem_rdata;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      case (ph)
        0: if (p_ifr || p_dr) begin
          win_d   = p_dr && (!p_ifr || !last_d);
          last_d  = win_d;
          ph      = 1;
          grants.push_back(win_d);
          lat     = contend ? 0 : int'($urandom_range(0, 3));
          e_addr  = win_d ? p_da : p_ifa;
          e_we    = win_d ? p_dwe : 1'b0;
          e_wdata = win_d ? p_dwd : '0;
        end
        1: if (p_ack) begin
          ph = 2;
          if (win_d) e_d_rd = p_rd; else e_if_rd = p_rd;
        end
        default: ph = 0;
      endcase
      chk("rnd_mem_req", mem_req, ph == 1);
      if (ph == 1) begin
        chk("rnd_mem_addr", mem_addr, e_addr);
        chk("rnd_mem_we", mem_we, e_we);
        chk("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      chk("rnd_if_ack", if_ack, ph == 2 && !win_d);
      chk("rnd_d_ack", d_ack, ph == 2 && win_d);
      chk("rnd_if_rdata", if_rdata, e_if_rd);
      chk("rnd_d_rdata", d_rdata, e_d_rd);
      chk("rnd_timeout_err", timeout_err, 1'b0);
      if (ph == 1) begin
        mem_ack = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      mem_rdata = $urandom;
      if (ph == 2 && !win_d) begin
        if (contend || $urandom_range(0, 1) == 1) begin
          if_req = 1'b1; if_addr = $urandom & 32'h0000_FFFC;
        end else if_req = 1'b0;
      end else if (!if_req && (contend || $urandom_range(0, 2) == 0)) begin
        if_req = 1'b1; if_addr = $urandom & 32'h0000_FFFC;
      end
      if (ph == 2 && win_d) begin
        if (contend || $urandom_range(0, 1) == 1) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = $urandom & 32'h0000_FFFC; d_wdata = $urandom;
        end else d_req = 1'b0;
      end else if (!d_req && (contend || $urandom_range(0, 2) == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom & 32'h0000_FFFC; d_wdata = $urandom;
      end
      #1;
      chk("rnd_stall_if", stall_if, if_req && !(ph == 2 && !win_d));
      chk("rnd_stall_mem", stall_mem, d_req && !(ph == 2 && win_d));
      p_ifr = if_req; p_dr = d_req; p_dwe = d_we; p_ack = mem_ack;
      p_ifa = if_addr; p_da = d_addr; p_dwd = d_wdata; p_rd = mem_rdata;
    end
  endtask

  initial begin
    // Reset with both requests pending; first grant must go to data.
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h200; d_addr = 32'h80; d_wdata = 32'h55;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_ctl", {mem_req, mem_we, if_ack, d_ack, timeout_err}, 5'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    end
    rst = 1'b0;
    tick();
    chk("first_gnt_req", mem_req, 1'b1);
    chk("first_gnt_addr", mem_addr, 32'h80);
    chk("first_gnt_stall_if", stall_if, 1'b1);
    chk("first_gnt_stall_mem", stall_mem, 1'b1);
    mem_rdata = 32'h1234_5678; mem_ack = 1'b1;
    tick();
    chk("first_d_ack", {d_ack, if_ack, mem_req}, 3'b100);
    chk("first_d_rdata", d_rdata, 32'h1234_5678);
    chk("first_stall_mem_ack", stall_mem, 1'b0);
    do_reset();

    // Single fetch, zero-wait memory.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("fetch_req", {mem_req, mem_we}, 2'b10);
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_wdata", mem_wdata, 32'h0);
    chk("fetch_stall", stall_if, 1'b1);
    mem_rdata = 32'h0050_0093; mem_ack = 1'b1;
    tick();
    chk("fetch_ack", {if_ack, d_ack, mem_req}, 3'b100);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    chk("fetch_stall_ack", stall_if, 1'b0);
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
    chk("fetch_ack_pulse", if_ack, 1'b0);
    chk("fetch_rdata_hold", if_rdata, 32'h0050_0093);

    // Store then load with two wait states.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick();
    for (int g = 0; g < 3; g++) begin
      chk("store_hold_ctl", {mem_req, mem_we}, 2'b11);
      chk("store_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("store_hold_addr", mem_addr, 32'h40);
      if (g < 2) tick();
    end
    mem_rdata = 32'h0BAD_F00D; mem_ack = 1'b1;
    tick();
    chk("store_ack", d_ack, 1'b1);
    mem_ack = 1'b0; d_we = 1'b0;
    tick();
    chk("resp_no_grant", {mem_req, d_ack}, 2'b00);
    tick();
    chk("load_req", {mem_req, mem_we}, 2'b10);
    chk("load_addr", mem_addr, 32'h40);
    tick(); tick();
    mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b1;
    tick();
    chk("load_ack", d_ack, 1'b1);
    chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
    mem_ack = 1'b0; d_req = 1'b0;
    tick();

    // Continuous contention: grants alternate starting with data.
    do_reset();
    run_engine(40, 1'b1);
    chk("cont_ngrants_ge4", grants.size() >= 4, 1'b1);
    if (grants.size() >= 4)
      chk("cont_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b1010);

    // Timeout: a load first leaves nonzero d_rdata, then memory never answers.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    tick();
    mem_rdata = 32'hA5A5_A5A5; mem_ack = 1'b1;
    tick();
    chk("pre_to_rdata", d_rdata, 32'hA5A5_A5A5);
    mem_ack = 1'b0;
    tick(); tick();
    chk("to_gnt", mem_req, 1'b1);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("to_wait", {mem_req, d_ack, timeout_err}, 3'b100);
    end
    tick();
    chk("to_abort", {mem_req, d_ack, timeout_err}, 3'b011);
    chk("to_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    tick(); tick();
    chk("to_sticky", {timeout_err, d_ack}, 2'b10);

    // Reset in the middle of a data grant, then a late ack.
    d_req = 1'b1; d_addr = 32'h48;
    tick();
    chk("midrst_gnt", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_abort", {mem_req, d_ack, timeout_err}, 3'b000);
    rst = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    chk("late_ack_ign", {mem_req, d_ack, if_ack}, 3'b000);
    chk("late_ack_rdata", d_rdata, 32'h0);
    mem_ack = 1'b0;
    tick();
    chk("late_ack_noack", d_ack, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    run_engine(1500, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
